cardinal_nic: RTL and testbench

Network interface controller between one processing element (PE) and its local router port in the 4x4 Cardinal mesh. It is the unit instantiated inside each `nic_pe_module`:
- On the PE side it exposes four memory-mapped 64-bit registers.
- On the network side it drives the router's PE injection port and consumes the PE ejection port.
- It holds one 64-bit packet in each direction and uses a ready/send handshake qualified by the mesh's even/odd virtual-channel polarity.

---
 rtl/cardinal_nic.sv | 90 +++++++++
 tb/tb_cardinal_nic.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/cardinal_nic.sv
// Cardinal mesh NIC: single-packet ejection/injection buffers, PE-mapped registers,
// and a ready/send handshake gated by the packet's VC bit against mesh polarity.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);

  logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d;
  logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
  logic                  in_full_q, in_full_d;
  logic                  out_full_q, out_full_d;

  logic pe_rd, pe_wr;
  logic rd_in_buf, wr_out_buf;

  assign pe_rd      = nicEn & ~nicWrEn;
  assign pe_wr      = nicEn & nicWrEn;
  assign rd_in_buf  = pe_rd & (addr == ADDR_WIDTH'(0));
  assign wr_out_buf = pe_wr & (addr == ADDR_WIDTH'(2));

  assign net_ri = ~in_full_q;
  assign net_do = out_buf_q;
  // A packet may only leave in the mesh phase that matches its VC bit.
  assign net_so = out_full_q & net_ro & (out_buf_q[DATA_WIDTH-1] == net_polarity);

  always_comb begin
    d_out = '0;
    if (pe_rd) begin
      case (addr)
        ADDR_WIDTH'(0): d_out = in_buf_q;
        ADDR_WIDTH'(1): d_out = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
        ADDR_WIDTH'(2): d_out = out_buf_q;
        default:        d_out = {{(DATA_WIDTH-1){1'b0}}, out_full_q};
      endcase
    end
  end

  always_comb begin
    in_buf_d  = in_buf_q;
    in_full_d = in_full_q;
    if (net_si & ~in_full_q) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end else if (rd_in_buf & in_full_q) begin
      in_full_d = 1'b0;
    end
  end

  // A send frees the buffer, so a same-cycle write still sees it full and is dropped.
  always_comb begin
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;
    if (net_so) begin
      out_full_d = 1'b0;
    end else if (wr_out_buf & ~out_full_q) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Bench for cardinal_nic: directed vector table for the corner sequences, then
// randomized traffic checked against a queue-based packet-level reference.
module tb_cardinal_nic;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [63:0] d_in, d_out, net_di, net_do;
  logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  cardinal_nic #(.DATA_WIDTH(64), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit [1:0]    addr;
    bit          en, wr;
    logic [63:0] din;
    bit          si;
    logic [63:0] di;
    bit          ro, pol, chk;
    logic [63:0] e_dout;
    bit          e_ri, e_so;
    logic [63:0] e_do;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // Reference: each direction is a queue holding at most one packet; the
  // "last" values model what the visible buffer register shows.
  logic [63:0] in_q[$];
  logic [63:0] out_q[$];
  logic [63:0] in_last, out_last;

  function automatic vec_t mk(bit rst, bit [1:0] a, bit en, bit wr, logic [63:0] din,
                              bit si, logic [63:0] di, bit ro, bit pol, bit chk,
                              logic [63:0] e_dout, bit e_ri, bit e_so, logic [63:0] e_do);
    vec_t v;
    v.rst = rst; v.addr = a; v.en = en; v.wr = wr; v.din = din;
    v.si = si; v.di = di; v.ro = ro; v.pol = pol; v.chk = chk;
    v.e_dout = e_dout; v.e_ri = e_ri; v.e_so = e_so; v.e_do = e_do;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t model_expect(input vec_t v);
    vec_t r = v;
    r.e_ri = (in_q.size() == 0);
    r.e_so = (out_q.size() != 0) && v.ro && (out_q[0][63] == v.pol);
    r.e_do = out_last;
    r.e_dout = 64'd0;
    if (v.en && !v.wr) begin
      case (v.addr)
        2'd0: r.e_dout = in_last;
        2'd1: r.e_dout = 64'(in_q.size());
        2'd2: r.e_dout = out_last;
        default: r.e_dout = 64'(out_q.size());
      endcase
    end
    return r;
  endfunction

  task automatic model_edge(input vec_t v, input bit sent);
    if (v.rst) begin
      in_q.delete(); out_q.delete();
      in_last = '0; out_last = '0;
    end else begin
      if (v.si && in_q.size() == 0) begin
        in_q.push_back(v.di); in_last = v.di;
      end else if (v.en && !v.wr && v.addr == 2'd0 && in_q.size() != 0) begin
        void'(in_q.pop_front());
      end
      if (sent) begin
        void'(out_q.pop_front());
      end else if (v.en && v.wr && v.addr == 2'd2 && out_q.size() == 0) begin
        out_q.push_back(v.din); out_last = v.din;
      end
    end
  endtask

  // Drive one cycle at the falling edge, check before the rising edge, then advance.
  task automatic step(input vec_t v, input bit use_model);
    vec_t m;
    reset = v.rst; addr = v.addr; nicEn = v.en; nicWrEn = v.wr; d_in = v.din;
    net_si = v.si; net_di = v.di; net_ro = v.ro; net_polarity = v.pol;
    #1;
    m = model_expect(v);
    if (use_model || v.chk) begin
      cmp("d_out",  d_out,        use_model ? m.e_dout : v.e_dout);
      cmp("net_ri", 64'(net_ri),  use_model ? 64'(m.e_ri) : 64'(v.e_ri));
      cmp("net_so", 64'(net_so),  use_model ? 64'(m.e_so) : 64'(v.e_so));
      cmp("net_do", net_do,       use_model ? m.e_do : v.e_do);
    end
    @(posedge clk);
    model_edge(v, m.e_so);
    @(negedge clk);
  endtask

  localparam logic [63:0] P  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] A  = 64'h8000_0000_0000_00AA;
  localparam logic [63:0] B7 = 64'h8000_0000_0000_0007;

  vec_t tbl[$];

  initial begin
    in_last = '0; out_last = '0;
    //            rst a  en wr din  si di                      ro pol chk dout ri so do
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 64'hF0F0,               0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0,  1, 64'h0F0F,               0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  0, 0,                      0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 0, 0,  0, 0,                      0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0,  1, P,                      0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  1, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  0, 0,                      0, 0, 1, P, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0,  0, 0,                      0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0,  0, 0,                      0, 0, 1, P, 1, 0, 0));
    tbl.push_back(mk(0, 2, 1, 1, A,  0, 0,                      1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 0, 0,  0, 0,                      1, 1, 1, 1, 1, 1, A));
    tbl.push_back(mk(0, 3, 1, 0, 0,  0, 0,                      1, 0, 1, 0, 1, 0, A));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 0,                      1, 1, 1, 0, 1, 0, A));
    tbl.push_back(mk(0, 2, 1, 1, 1,  0, 0,                      0, 0, 1, 0, 1, 0, A));
    tbl.push_back(mk(0, 2, 1, 1, 2,  0, 0,                      0, 1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 2, 1, 0, 0,  0, 0,                      0, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 3, 1, 0, 0,  0, 0,                      1, 1, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 2, 1, 1, 5,  0, 0,                      1, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 3, 1, 0, 0,  0, 0,                      1, 1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 2, 1, 0, 0,  0, 0,                      1, 0, 1, 1, 1, 0, 1));
    tbl.push_back(mk(0, 2, 1, 1, B7, 1, 64'hAAAA_5555_AAAA_5555, 0, 1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 0, 0,  0, 0,                      0, 0, 1, 1, 0, 0, B7));
    tbl.push_back(mk(0, 1, 1, 0, 0,  0, 0,                      1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 3, 1, 0, 0,  0, 0,                      1, 1, 1, 0, 1, 0, 0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0);

    // Randomized traffic with a free-running polarity phase.
    for (int c = 0; c < 600; c++) begin
      vec_t v;
      v = mk($urandom_range(0, 49) == 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             {$urandom(), $urandom()}, $urandom_range(0, 1) == 1,
             {$urandom(), $urandom()}, $urandom_range(0, 3) != 0,
             c[0], 1'b0, 0, 0, 0, 0);
      step(v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
